mem_burst_master: RTL and testbench
===================================

Name: mem_burst_master

Overview:
Initiator for the single-port memory interface (wr_en/rd_en/addr/datain in, dataout/DataValid out; combinational read, write on clock edge). It accepts burst read/write requests over a valid/ready command port and sequences one memory beat per cycle with auto-incrementing address. It streams write data in and read data out over valid/ready, and flags invalid read returns. It sits between the test/processor side and the memory.

Parameters:
ADDRWIDTH, definitions::ADDRWIDTH, memory address width
DATAWIDTH, definitions::DATAWIDTH, memory data width
LENWIDTH, 4, burst length field width; beats = req_len + 1 (1..2**LENWIDTH)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  burst request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  ADDRWIDTH  start address
req_len  input  LENWIDTH  beats minus one
wdata_valid  input  1  write beat valid
wdata_ready  output  1  write beat consumed
wdata  input  DATAWIDTH  write beat data
rdata_valid  output  1  read beat valid (registered)
rdata_ready  input  1  consumer accepts read beat
rdata  output  DATAWIDTH  read beat data
rdata_last  output  1  marks final read beat
done  output  1  one-cycle pulse at burst completion
err  output  1  sticky: a read returned with DataValid low
mem_wr_en  output  1  to memory wr_en
mem_rd_en  output  1  to memory rd_en
mem_addr  output  ADDRWIDTH  to memory addr
mem_datain  output  DATAWIDTH  to memory datain
mem_dataout  input  DATAWIDTH  from memory dataout
mem_data_valid  input  1  from memory DataValid

Behaviour:
- One clock domain; reset is synchronous and active-high on clk. Reset: state IDLE; rdata_valid, rdata_last, done, err = 0; rdata = 0; counters/address = 0. mem_wr_en and mem_rd_en are gated by !reset, so no access is issued in a reset cycle.
- States: IDLE, WRITE, READ.
- IDLE: req_ready = !rdata_valid. On accept: cur_addr <= req_addr, beats_left <= req_len, err <= 0. Next state is WRITE if req_write, else READ. No memory access occurs in the accept cycle.
- WRITE:
  - wdata_ready = 1; mem_wr_en = wdata_valid; mem_addr = cur_addr; mem_datain = wdata.
  - Beat occurs when wdata_valid. Gaps (wdata_valid = 0) stall with no access and no address change.
  - Per beat: cur_addr <= cur_addr + 1 (mod 2**ADDRWIDTH, FF wraps to 00); beats_left decrements.
  - Beat with beats_left == 0: go to IDLE; done = 1 the following cycle.
- READ:
  - issue = !rdata_valid || rdata_ready; mem_rd_en = issue; mem_addr = cur_addr.
  - On issue: rdata <= mem_dataout; rdata_valid <= 1; rdata_last <= (beats_left == 0); err <= err | !mem_data_valid. Address and count update as in WRITE.
  - No issue: rdata/rdata_valid hold (backpressure). When rdata_valid && rdata_ready and no new issue, rdata_valid <= 0.
  - Last issue: go to IDLE. done = 1 in the cycle after rdata_valid && rdata_ready && rdata_last.
  - req_ready stays low until that final beat is consumed.
- Throughput: 1 beat/cycle when unstalled. Write latency: wdata appears in memory at the edge of its beat cycle. Read latency: rdata valid 1 cycle after issue.
- mem_wr_en and mem_rd_en are never both high. Outside their active state, mem_addr and mem_datain = 0.
- Address wraps silently; beat count is never affected by the wrap.
- Reset mid-burst abandons the burst. Memory keeps writes already done, no done pulse is produced, and rdata_valid drops after the reset edge.

Test Plan:
- Write req_addr=0x10, req_len=3, wdata A0,A1,A2,A3 back-to-back -> mem_wr_en 4 consecutive cycles at addr 10..13; done pulse 1 cycle after the last beat.
- Read req_addr=0x10, req_len=3, rdata_ready=1 -> rdata A0..A3 on 4 consecutive cycles; rdata_last only with A3; done after A3; err=0.
- Write req_addr=max (0xFF at 8-bit), req_len=3 -> addresses FF,00,01,02; read back of those addresses returns the written data.
- Read len=3 with rdata_ready toggling 1,0,0,1,... -> no beat lost or duplicated, rdata stable while stalled, mem_rd_en low while stalled, req_ready low until the last beat is consumed.
- Write len=2 with wdata_valid gaps (1,0,1,0,1) -> exactly 3 writes to consecutive addresses; address holds across gaps.
- Assert reset during beat 2 of a 4-beat write -> mem_wr_en low in the reset cycle, beats 0-1 persist, no done, req_ready = 1 after reset. Separately, drive mem_data_valid=0 on one read beat -> err=1 held until the next accepted request.

Source files
------------

// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_master
// Description : Burst initiator for a single-port memory (combinational read,
//               clocked write). Accepts read/write burst requests, issues one
//               memory beat per cycle with an auto-incrementing address, and
//               streams write/read data over valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_master #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 8,
  parameter int LENWIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [LENWIDTH-1:0]  req_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rdata_last,
  output logic                 done,
  output logic                 err,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_datain,
  input  logic [DATAWIDTH-1:0] mem_dataout,
  input  logic                 mem_data_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDRWIDTH-1:0]  r_cur_addr;
  logic [LENWIDTH-1:0]   r_beats_left;
  logic [DATAWIDTH-1:0]  r_rdata;
  logic                  r_rdata_valid;
  logic                  r_rdata_last;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_wr_beat;
  logic                  w_rd_issue;
  logic                  w_last_beat;
  logic                  w_rd_consume;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and memory/handshake strobes; memory strobes are
  // gated by reset so no access escapes during a reset cycle.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    wdata_ready  = 1'b0;
    mem_wr_en    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    mem_datain   = '0;
    w_accept     = 1'b0;
    w_wr_beat    = 1'b0;
    w_rd_issue   = 1'b0;
    w_last_beat  = (r_beats_left == '0);
    w_rd_consume = r_rdata_valid && rdata_ready;
    case (r_state)
      S_IDLE: begin
        // A new burst waits until the previous final read beat is taken.
        req_ready = !r_rdata_valid;
        w_accept  = req_valid && !r_rdata_valid;
        if (w_accept) begin
          w_next_state = req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wdata_ready = 1'b1;
        mem_addr    = r_cur_addr;
        mem_datain  = wdata;
        w_wr_beat   = wdata_valid && !reset;
        mem_wr_en   = w_wr_beat;
        if (wdata_valid && w_last_beat) begin
          w_next_state = S_IDLE;
        end
      end
      S_READ: begin
        mem_addr   = r_cur_addr;
        w_rd_issue = (!r_rdata_valid || rdata_ready) && !reset;
        mem_rd_en  = w_rd_issue;
        if (w_rd_issue && w_last_beat) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Burst address/count, read-data output register, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_addr    <= '0;
      r_beats_left  <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= (w_wr_beat && w_last_beat) || (w_rd_consume && r_rdata_last);
      if (w_accept) begin
        r_cur_addr   <= req_addr;
        r_beats_left <= req_len;
        r_err        <= 1'b0;
      end
      if (w_wr_beat || w_rd_issue) begin
        r_cur_addr   <= r_cur_addr + 1'b1;
        r_beats_left <= r_beats_left - 1'b1;
      end
      if (w_rd_issue) begin
        r_rdata       <= mem_dataout;
        r_rdata_valid <= 1'b1;
        r_rdata_last  <= w_last_beat;
        r_err         <= r_err | !mem_data_valid;
      end else if (w_rd_consume) begin
        r_rdata_valid <= 1'b0;
      end
    end
  end

  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign rdata_last  = r_rdata_last;
  assign done        = r_done;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_burst_master
// Description : Directed self-checking bench for mem_burst_master with a
//               256 x 8 single-port memory model attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_master;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid;
  logic       rdata_ready;
  logic [7:0] rdata;
  logic       rdata_last;
  logic       done;
  logic       err;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_datain;
  logic [7:0] mem_dataout;
  logic       mem_data_valid;

  logic [7:0] tb_mem [0:255];

  int n_cmp;
  int n_err;

  mem_burst_master #(
    .ADDRWIDTH(8),
    .DATAWIDTH(8),
    .LENWIDTH (4)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .wdata         (wdata),
    .rdata_valid   (rdata_valid),
    .rdata_ready   (rdata_ready),
    .rdata         (rdata),
    .rdata_last    (rdata_last),
    .done          (done),
    .err           (err),
    .mem_wr_en     (mem_wr_en),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_datain    (mem_datain),
    .mem_dataout   (mem_dataout),
    .mem_data_valid(mem_data_valid)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_addr] <= mem_datain;
  end
  assign mem_dataout = tb_mem[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Back-to-back write burst; data for beat i is base+i.
  task automatic wr_burst(input logic [7:0] addr, input logic [3:0] len, input logic [7:0] base);
    logic [7:0] ea;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
    #1;
    check_eq("wr_req_ready", req_ready, 1);
    check_eq("wr_accept_no_access", mem_wr_en, 0);
    step;
    req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata_valid = 1'b1;
      wdata = base + 8'(i);
      ea = addr + 8'(i);
      #1;
      check_eq("wr_en", mem_wr_en, 1);
      check_eq("wr_addr", mem_addr, ea);
      check_eq("wr_datain", mem_datain, base + 8'(i));
      check_eq("wr_no_rd", mem_rd_en, 0);
      check_eq("wr_done_early", done, 0);
      step;
    end
    wdata_valid = 1'b0;
    #1;
    check_eq("wr_done", done, 1);
    check_eq("wr_idle_no_wr", mem_wr_en, 0);
    for (int i = 0; i <= int'(len); i++) begin
      ea = addr + 8'(i);
      check_eq("wr_mem", tb_mem[ea], base + 8'(i));
    end
    step;
    check_eq("wr_done_pulse", done, 0);
  endtask

  // Unstalled read burst expecting base+k on beat k.
  task automatic rd_burst(input logic [7:0] addr, input logic [3:0] len, input logic [7:0] base);
    logic [7:0] ea;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len; rdata_ready = 1'b1;
    #1;
    check_eq("rd_req_ready", req_ready, 1);
    check_eq("rd_accept_no_access", mem_rd_en, 0);
    step;
    req_valid = 1'b0;
    for (int k = 0; k <= int'(len) + 1; k++) begin
      #1;
      ea = addr + 8'(k);
      if (k <= int'(len)) begin
        check_eq("rd_en", mem_rd_en, 1);
        check_eq("rd_addr", mem_addr, ea);
      end else begin
        check_eq("rd_en_end", mem_rd_en, 0);
        check_eq("rd_req_ready_busy", req_ready, 0);
      end
      if (k > 0) begin
        check_eq("rd_valid", rdata_valid, 1);
        check_eq("rd_data", rdata, base + 8'(k - 1));
        check_eq("rd_last", rdata_last, (k == int'(len) + 1));
      end else begin
        check_eq("rd_valid_first", rdata_valid, 0);
      end
      check_eq("rd_no_wr", mem_wr_en, 0);
      step;
    end
    #1;
    check_eq("rd_done", done, 1);
    check_eq("rd_valid_drop", rdata_valid, 0);
    check_eq("rd_req_ready_after", req_ready, 1);
    check_eq("rd_err", err, 0);
    step;
  endtask

  initial begin
    int nw;
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_len = 4'h0;
    wdata_valid = 1'b0; wdata = 8'h00; rdata_ready = 1'b0; mem_data_valid = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdata_valid", rdata_valid, 0);
    check_eq("rst_rdata_last", rdata_last, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_wr_en", mem_wr_en, 0);
    check_eq("rst_rd_en", mem_rd_en, 0);
    check_eq("rst_addr", mem_addr, 0);
    reset = 1'b0;
    step;

    // Basic write then read-back at 0x10.
    wr_burst(8'h10, 4'd3, 8'hA0);
    rd_burst(8'h10, 4'd3, 8'hA0);

    // Address wrap at the top of memory.
    wr_burst(8'hFF, 4'd3, 8'hB0);
    rd_burst(8'hFF, 4'd3, 8'hB0);

    // Read with consumer backpressure: ready high every third cycle.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_len = 4'd3; rdata_ready = 1'b0;
    #1;
    step;
    req_valid = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      rdata_ready = (c % 3 == 0);
      #1;
      check_eq("stall_rd_en", mem_rd_en, (c % 3 == 0) && (c <= 9));
      if ((c % 3 == 0) && (c <= 9)) check_eq("stall_addr", mem_addr, 8'h10 + c / 3);
      if (c > 0) begin
        check_eq("stall_valid", rdata_valid, 1);
        check_eq("stall_data", rdata, 8'hA0 + (c - 1) / 3);
        check_eq("stall_last", rdata_last, (c >= 10));
      end
      check_eq("stall_req_ready", req_ready, 0);
      step;
    end
    rdata_ready = 1'b0;
    #1;
    check_eq("stall_done", done, 1);
    check_eq("stall_valid_drop", rdata_valid, 0);
    check_eq("stall_req_ready_after", req_ready, 1);
    step;

    // Write with data gaps: valid pattern 1,0,1,0,1.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_len = 4'd2;
    #1;
    step;
    req_valid = 1'b0;
    nw = 0;
    for (int c = 0; c <= 4; c++) begin
      wdata_valid = (c % 2 == 0);
      wdata = 8'hC0 + 8'(c / 2);
      #1;
      check_eq("gap_wr_en", mem_wr_en, (c % 2 == 0));
      check_eq("gap_addr", mem_addr, 8'h40 + (c + 1) / 2);
      if (mem_wr_en) nw++;
      step;
    end
    wdata_valid = 1'b0;
    #1;
    check_eq("gap_done", done, 1);
    check_eq("gap_write_count", nw, 3);
    check_eq("gap_mem0", tb_mem[8'h40], 8'hC0);
    check_eq("gap_mem1", tb_mem[8'h41], 8'hC1);
    check_eq("gap_mem2", tb_mem[8'h42], 8'hC2);
    check_eq("gap_mem3_untouched", tb_mem[8'h43], 8'h00);
    step;

    // Reset during beat 2 of a 4-beat write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h80; req_len = 4'd3;
    #1;
    step;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1'b1;
      wdata = 8'hD0 + 8'(i);
      step;
    end
    wdata = 8'hD2;
    reset = 1'b1;
    #1;
    check_eq("rstmid_wr_en", mem_wr_en, 0);
    step;
    reset = 1'b0;
    wdata_valid = 1'b0;
    #1;
    check_eq("rstmid_req_ready", req_ready, 1);
    check_eq("rstmid_done", done, 0);
    check_eq("rstmid_mem0", tb_mem[8'h80], 8'hD0);
    check_eq("rstmid_mem1", tb_mem[8'h81], 8'hD1);
    check_eq("rstmid_mem2", tb_mem[8'h82], 8'h00);
    step;
    check_eq("rstmid_no_done", done, 0);

    // Invalid read return sets a sticky error, cleared by the next accept.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_len = 4'd1; rdata_ready = 1'b1;
    #1;
    step;
    req_valid = 1'b0;
    #1;
    check_eq("err_rd_en0", mem_rd_en, 1);
    step;
    mem_data_valid = 1'b0;
    #1;
    check_eq("err_rd_en1", mem_rd_en, 1);
    check_eq("err_before", err, 0);
    step;
    mem_data_valid = 1'b1;
    #1;
    check_eq("err_set", err, 1);
    check_eq("err_data", rdata, 8'hA1);
    check_eq("err_last", rdata_last, 1);
    step;
    check_eq("err_done", done, 1);
    check_eq("err_hold0", err, 1);
    step;
    step;
    check_eq("err_hold1", err, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h90; req_len = 4'd0;
    #1;
    check_eq("err_hold_accept", err, 1);
    step;
    req_valid = 1'b0;
    check_eq("err_cleared", err, 0);
    wdata_valid = 1'b1;
    wdata = 8'hE0;
    step;
    wdata_valid = 1'b0;
    check_eq("err_wr_done", done, 1);
    check_eq("err_wr_mem", tb_mem[8'h90], 8'hE0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
